// File: rtl/sd_adc_pkg.sv
//==============================================================================
// Module      : sd_adc_pkg
// Description : Shared defaults and result saturation helper for sd_adc_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sd_adc_pkg;

    localparam int OSR_LOG2_DEF    = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // A full window of ones (2^osr_log2) does not fit the result; clamp to all-ones.
    function automatic logic [31:0] sat_count(input logic [31:0] sum, input int osr_log2);
        logic [31:0] max_code;
        max_code = (32'd1 << osr_log2) - 32'd1;
        return (sum > max_code) ? max_code : sum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
//==============================================================================
// Module      : bit_sync
// Description : N-flop single-bit synchronizer, synchronous reset to 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[N-2:0], d};
        end
    end

    assign q = r_chain[N-1];

endmodule

`default_nettype wire

// File: rtl/sd_adc_ctrl.sv
//==============================================================================
// Module      : sd_adc_ctrl
// Description : First-order sigma-delta back end: comparator sync, 1-bit
//               feedback and OSR-window ones-count decimator with handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sd_adc_ctrl
    import sd_adc_pkg::*;
#(
    parameter int OSR_LOG2    = OSR_LOG2_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                cmp_in,
    output logic                fb_out,
    output logic [OSR_LOG2-1:0] result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                overrun
);

    localparam logic [OSR_LOG2-1:0] c_win_max = '1;

    logic                w_cmp_s;
    logic [OSR_LOG2-1:0] r_win;
    logic [OSR_LOG2:0]   r_acc;
    logic [OSR_LOG2:0]   w_sum;
    logic [OSR_LOG2-1:0] w_sat;
    logic                w_tc;
    logic                w_accept;

    bit_sync #(
        .N (SYNC_STAGES)
    ) u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (w_cmp_s)
    );

    // The TC cycle's own feedback bit is folded in here, so acc never holds a full window.
    assign w_sum    = r_acc + {{OSR_LOG2{1'b0}}, fb_out};
    assign w_sat    = OSR_LOG2'(sat_count(32'(w_sum), OSR_LOG2));
    assign w_tc     = ena && (r_win == c_win_max);
    assign w_accept = result_valid && result_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_out       <= 1'b0;
            r_win        <= '0;
            r_acc        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            fb_out <= ena ? w_cmp_s : 1'b0;

            if (!ena) begin
                r_win <= '0;
                r_acc <= '0;
            end else if (w_tc) begin
                r_win <= '0;
                r_acc <= '0;
            end else begin
                r_win <= r_win + 1'b1;
                r_acc <= w_sum;
            end

            if (w_tc) begin
                result       <= w_sat;
                result_valid <= 1'b1;
                overrun      <= result_valid && !result_ready;
            end else if (w_accept) begin
                result_valid <= 1'b0;
                overrun      <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sd_adc_ctrl.sv
//==============================================================================
// Module      : tb_sd_adc_ctrl
// Description : Directed self-checking bench for sd_adc_ctrl (OSR_LOG2=8).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sd_adc_ctrl;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       cmp_in;
    logic       fb_out;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       overrun;

    int n_total;
    int n_bad;
    logic hist [0:520];

    sd_adc_ctrl #(
        .OSR_LOG2    (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .cmp_in       (cmp_in),
        .fb_out       (fb_out),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rst          = 1'b1;
        ena          = 1'b0;
        cmp_in       = 1'b0;
        result_ready = 1'b1;
        step(3);
        chk("rst_fb", fb_out, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_overrun", overrun, 0);

        // Constant low: first result lands 256 edges after enable.
        rst = 1'b0;
        ena = 1'b1;
        step(255);
        chk("low_early_valid", result_valid, 0);
        step(1);
        chk("low_valid", result_valid, 1);
        chk("low_result", result, 0);
        chk("low_overrun", overrun, 0);
        step(256);
        chk("low_period_valid", result_valid, 1);
        chk("low_result2", result, 0);
        chk("low_fb", fb_out, 0);

        // Constant high from reset: 3 zero cycles of pipeline fill, then saturation.
        rst    = 1'b1;
        cmp_in = 1'b1;
        step(2);
        chk("rst2_valid", result_valid, 0);
        rst = 1'b0;
        step(255);
        chk("high_early_valid", result_valid, 0);
        step(1);
        chk("high_valid", result_valid, 1);
        chk("high_first", result, 253);
        step(256);
        chk("high_valid2", result_valid, 1);
        chk("high_sat", result, 255);
        chk("high_fb", fb_out, 1);

        // 50% stream: fb after edge i equals the value driven before edge i-2.
        hist[0] = 1'b1;
        for (int i = 1; i <= 512; i++) begin
            cmp_in  = ~cmp_in;
            hist[i] = cmp_in;
            step(1);
            if (i >= 505) chk("fb_lag", fb_out, hist[i-2]);
        end
        chk("half_valid", result_valid, 1);
        chk("half_result", result, 128);

        // Backpressure: stream stops; leftover pipeline bits give 1+0+1 = 2.
        result_ready = 1'b0;
        cmp_in       = 1'b0;
        step(128);
        chk("bp_hold_result", result, 128);
        chk("bp_hold_overrun", overrun, 0);
        step(128);
        chk("bp_valid", result_valid, 1);
        chk("bp_result", result, 2);
        chk("bp_overrun", overrun, 1);
        step(10);
        chk("bp_stable_result", result, 2);
        chk("bp_stable_overrun", overrun, 1);
        result_ready = 1'b1;
        step(1);
        result_ready = 1'b0;
        chk("acc_valid", result_valid, 0);
        chk("acc_overrun", overrun, 0);
        step(245);
        chk("bp2_valid", result_valid, 1);
        chk("bp2_result", result, 0);
        chk("bp2_overrun", overrun, 0);

        // Ready pulse on the TC cycle: old accepted, new value loads.
        cmp_in = 1'b1;
        step(255);
        chk("tcacc_pre_valid", result_valid, 1);
        chk("tcacc_pre_result", result, 0);
        result_ready = 1'b1;
        step(1);
        chk("tcacc_valid", result_valid, 1);
        chk("tcacc_result", result, 253);
        chk("tcacc_overrun", overrun, 0);

        // Abort at window cycle 100 then re-enable for a fresh full window.
        step(100);
        chk("abort_pre_fb", fb_out, 1);
        ena = 1'b0;
        step(1);
        chk("abort_fb", fb_out, 0);
        step(50);
        chk("abort_no_result", result_valid, 0);
        chk("abort_result_held", result, 253);
        ena = 1'b1;
        step(255);
        chk("reen_early_valid", result_valid, 0);
        step(1);
        chk("reen_valid", result_valid, 1);
        chk("reen_result", result, 255);

        // Reset with a pending, overrun result mid-window.
        result_ready = 1'b0;
        step(256);
        chk("pre_rst_overrun", overrun, 1);
        step(50);
        rst = 1'b1;
        step(1);
        chk("mrst_fb", fb_out, 0);
        chk("mrst_result", result, 0);
        chk("mrst_valid", result_valid, 0);
        chk("mrst_overrun", overrun, 0);

        rst = 1'b0;
        ena = 1'b0;
        step(2);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
